// File: rtl/maze_plan_seq.sv
// -----------------------------------------------------------------------------
// maze_plan_seq
//
// Travel-plan sequencer for the MazeRunner robot. A 16-bit plan word from the
// UART command path is held as eight 2-bit directives, consumed LSB-first. Each
// time the line follower sees a line gap, the next directive becomes the active
// maneuver for the heading/motor datapath. The robot stops when the plan runs
// out (00 directive) or when a bump switch fires. A bump stop also enables the
// buzzer.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-high
//   cmd[15:0]     travel plan word, valid while cmd_rdy=1
//   cmd_rdy       a new plan word is available (level)
//   clr_cmd_rdy   one-cycle acknowledge of cmd
//   line_present  IR line detect (synchronized upstream)
//   BMPL_n        left bump switch, active-low (synchronized upstream)
//   BMPR_n        right bump switch, active-low (synchronized upstream)
//   go            motor enable
//   mnvr[1:0]     active maneuver: 00 follow, 01 veer right, 10 veer left,
//                 11 turn around
//   buzz_en       buzzer enable after a bump stop
//   plan_done     one-cycle pulse when the plan ends on a 00 directive
//   mnvr_cnt[3:0] maneuvers started since the last plan load, saturates at 8
// -----------------------------------------------------------------------------
module maze_plan_seq #(
  parameter int unsigned GAP_CYC   = 4096,
  parameter int unsigned MNVR_CYC  = 262144,
  parameter int unsigned REACQ_CYC = 1024,
  parameter int unsigned CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic        line_present,
  input  logic        BMPL_n,
  input  logic        BMPR_n,
  output logic        go,
  output logic [1:0]  mnvr,
  output logic        buzz_en,
  output logic        plan_done,
  output logic [3:0]  mnvr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLLOW,
    S_GAP,
    S_MNVR,
    S_REACQ,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] MNVR_LAST  = CNT_W'(MNVR_CYC - 1);
  localparam logic [CNT_W-1:0] REACQ_LAST = CNT_W'(REACQ_CYC - 1);

  state_t           state, state_nxt;
  logic [15:0]      plan, plan_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       mnvr_nxt;
  logic             buzz_nxt, done_nxt, clr_nxt, go_nxt;
  logic [3:0]       mcnt_nxt;

  logic bump;
  logic ack;
  logic load;
  logic active;

  assign bump   = ~BMPL_n | ~BMPR_n;
  // The acknowledge is held off while the previous pulse is still out, so a
  // slow-to-clear cmd_rdy cannot produce a back-to-back double pulse.
  assign ack    = cmd_rdy & ~clr_cmd_rdy;
  assign load   = ack & (cmd != 16'h0000);
  assign active = (state == S_FOLLOW) || (state == S_GAP) ||
                  (state == S_MNVR)   || (state == S_REACQ);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Bump wins over every other transition out of an
  // active state, including the GAP decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    if (active && bump) begin
      state_nxt = S_STOP;
    end else begin
      case (state)
        S_IDLE, S_STOP: if (load) state_nxt = S_FOLLOW;
        S_FOLLOW:       if (!line_present && cnt == GAP_LAST) state_nxt = S_GAP;
        S_GAP:          state_nxt = (plan[1:0] == 2'b00) ? S_STOP : S_MNVR;
        S_MNVR:         if (cnt == MNVR_LAST) state_nxt = S_REACQ;
        S_REACQ:        if (line_present && cnt == REACQ_LAST) state_nxt = S_FOLLOW;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next values for the registered outputs and the datapath (plan, counter).
  // ---------------------------------------------------------------------------
  always_comb begin
    plan_nxt = plan;
    cnt_nxt  = '0;
    mnvr_nxt = mnvr;
    buzz_nxt = buzz_en;
    done_nxt = 1'b0;
    clr_nxt  = 1'b0;
    mcnt_nxt = mnvr_cnt;
    go_nxt   = (state_nxt == S_FOLLOW) || (state_nxt == S_GAP) ||
               (state_nxt == S_MNVR)   || (state_nxt == S_REACQ);

    if (active && bump) begin
      // Plan and maneuver count are left as they are; only a reload resumes.
      mnvr_nxt = 2'b00;
      buzz_nxt = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_STOP: begin
          clr_nxt  = ack;
          mnvr_nxt = 2'b00;
          if (load) begin
            plan_nxt = cmd;
            mcnt_nxt = 4'd0;
            buzz_nxt = 1'b0;
          end
        end
        S_FOLLOW: begin
          mnvr_nxt = 2'b00;
          // Counts consecutive line-absent cycles; any line sighting restarts.
          cnt_nxt  = line_present ? '0 : cnt + 1'b1;
        end
        S_GAP: begin
          if (plan[1:0] == 2'b00) begin
            done_nxt = 1'b1;
          end else begin
            mnvr_nxt = plan[1:0];
            plan_nxt = {2'b00, plan[15:2]};
            mcnt_nxt = (mnvr_cnt == 4'd8) ? 4'd8 : mnvr_cnt + 4'd1;
          end
        end
        S_MNVR: begin
          // Committed maneuver time; line_present is ignored here.
          cnt_nxt = (cnt == MNVR_LAST) ? '0 : cnt + 1'b1;
        end
        S_REACQ: begin
          if (line_present && cnt == REACQ_LAST) begin
            mnvr_nxt = 2'b00;
          end else begin
            cnt_nxt = line_present ? cnt + 1'b1 : '0;
          end
        end
        default: begin
          mnvr_nxt = 2'b00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plan        <= '0;
      cnt         <= '0;
      mnvr        <= 2'b00;
      buzz_en     <= 1'b0;
      plan_done   <= 1'b0;
      clr_cmd_rdy <= 1'b0;
      mnvr_cnt    <= 4'd0;
      go          <= 1'b0;
    end else begin
      plan        <= plan_nxt;
      cnt         <= cnt_nxt;
      mnvr        <= mnvr_nxt;
      buzz_en     <= buzz_nxt;
      plan_done   <= done_nxt;
      clr_cmd_rdy <= clr_nxt;
      mnvr_cnt    <= mcnt_nxt;
      go          <= go_nxt;
    end
  end

endmodule

// File: tb/tb_maze_plan_seq.sv
// -----------------------------------------------------------------------------
// tb_maze_plan_seq
//
// Directed bench for maze_plan_seq with short timing parameters. A vector
// table covers plan load, gap debounce and one complete maneuver; hand-written
// sequences cover the full 8-directive plan, bump stops, bump/gap collision
// and asynchronous reset. Inputs change and outputs are sampled 1 time unit
// after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_maze_plan_seq;

  localparam int GAP   = 8;
  localparam int MNV   = 16;
  localparam int REACQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic        line_present = 1'b1;
  logic        BMPL_n = 1'b1;
  logic        BMPR_n = 1'b1;
  logic        go;
  logic [1:0]  mnvr;
  logic        buzz_en;
  logic        plan_done;
  logic [3:0]  mnvr_cnt;

  int checks = 0;
  int errors = 0;

  maze_plan_seq #(
    .GAP_CYC  (GAP),
    .MNVR_CYC (MNV),
    .REACQ_CYC(REACQ),
    .CNT_W    (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .line_present(line_present),
    .BMPL_n      (BMPL_n),
    .BMPR_n      (BMPR_n),
    .go          (go),
    .mnvr        (mnvr),
    .buzz_en     (buzz_en),
    .plan_done   (plan_done),
    .mnvr_cnt    (mnvr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic [15:0] cmd;
    logic        line;
    logic        bl_n;
    logic        br_n;
    logic        e_go;
    logic [1:0]  e_mnvr;
    logic        e_buzz;
    logic        e_done;
    logic        e_clr;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_go, input logic [1:0] e_mnvr,
                           input logic e_buzz, input logic e_done, input logic e_clr,
                           input logic [3:0] e_cnt);
    check({tag, ".go"},        {15'd0, go},          {15'd0, e_go});
    check({tag, ".mnvr"},      {14'd0, mnvr},        {14'd0, e_mnvr});
    check({tag, ".buzz_en"},   {15'd0, buzz_en},     {15'd0, e_buzz});
    check({tag, ".plan_done"}, {15'd0, plan_done},   {15'd0, e_done});
    check({tag, ".clr"},       {15'd0, clr_cmd_rdy}, {15'd0, e_clr});
    check({tag, ".mnvr_cnt"},  {12'd0, mnvr_cnt},    {12'd0, e_cnt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rdy, input logic [15:0] c, input logic line,
                     input logic bl_n, input logic br_n, input logic e_go,
                     input logic [1:0] e_mnvr, input logic e_buzz, input logic e_done,
                     input logic e_clr, input logic [3:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.cmd = c; v.line = line; v.bl_n = bl_n; v.br_n = br_n;
    v.e_go = e_go; v.e_mnvr = e_mnvr; v.e_buzz = e_buzz; v.e_done = e_done;
    v.e_clr = e_clr; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Load a plan word from IDLE/STOPPED; acknowledge and go appear after one edge.
  task automatic load_plan(input logic [15:0] c, input string tag);
    cmd = c;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    check_all(tag, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  // GAP line-absent cycles (FOLLOW->GAP), then one more edge (GAP->next).
  task automatic run_gap();
    line_present = 1'b0;
    repeat (GAP) step();
    line_present = 1'b1;
    step();
  endtask

  // With the line present, a maneuver lasts MNV+REACQ cycles after GAP.
  task automatic finish_mnvr(input logic [1:0] exp_m, input string tag);
    repeat (MNV + REACQ - 1) step();
    check({tag, ".hold"}, {14'd0, mnvr}, {14'd0, exp_m});
    step();
    check({tag, ".end"}, {14'd0, mnvr}, 16'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    #2 rst = 1'b1;
    #1;
    check_all("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    step();
    rst = 1'b0;

    // ---------------- table: load, debounce, one maneuver, plan end -------
    add(1, 16'h0000, 1, 1, 1,  0, 2'b00, 0, 0, 1, 0);  // cmd=0 acked, stay IDLE
    add(0, 16'h0000, 1, 1, 1,  0, 2'b00, 0, 0, 0, 0);  // single-cycle ack
    add(1, 16'h0002, 1, 1, 1,  1, 2'b00, 0, 0, 1, 0);  // load plan
    add(0, 16'h0002, 1, 1, 1,  1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < GAP - 1; i++)
      add(0, 16'h0002, 0, 1, 1,  1, 2'b00, 0, 0, 0, 0);  // 7-cycle dropout
    add(0, 16'h0002, 1, 1, 1,  1, 2'b00, 0, 0, 0, 0);    // line back, no effect
    for (int i = 0; i < GAP; i++)
      add(0, 16'h0002, 0, 1, 1,  1, 2'b00, 0, 0, 0, 0);  // real gap, last -> GAP
    for (int i = 0; i < MNV + REACQ; i++)
      add(0, 16'h0002, 1, 1, 1,  1, 2'b10, 0, 0, 0, 1);  // veer left held 20 cycles
    add(0, 16'h0002, 1, 1, 1,  1, 2'b00, 0, 0, 0, 1);    // back to FOLLOW
    for (int i = 0; i < GAP; i++)
      add(0, 16'h0002, 0, 1, 1,  1, 2'b00, 0, 0, 0, 1);  // next gap
    add(0, 16'h0002, 0, 1, 1,  0, 2'b00, 0, 1, 0, 1);    // plan exhausted
    add(0, 16'h0002, 1, 1, 1,  0, 2'b00, 0, 0, 0, 1);    // plan_done is a pulse

    for (int i = 0; i < vecs.size(); i++) begin
      cmd_rdy      = vecs[i].rdy;
      cmd          = vecs[i].cmd;
      line_present = vecs[i].line;
      BMPL_n       = vecs[i].bl_n;
      BMPR_n       = vecs[i].br_n;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_go, vecs[i].e_mnvr, vecs[i].e_buzz,
                vecs[i].e_done, vecs[i].e_clr, vecs[i].e_cnt);
    end
    cmd_rdy = 1'b0;
    line_present = 1'b1;

    // ---------------- full plan: eight turn-arounds then stop ------------
    load_plan(16'hFFFF, "full_load");
    for (int g = 1; g <= 8; g++) begin
      run_gap();
      check($sformatf("full%0d.mnvr", g), {14'd0, mnvr}, 16'd3);
      check($sformatf("full%0d.cnt", g), {12'd0, mnvr_cnt}, 16'(g));
      finish_mnvr(2'b11, $sformatf("full%0d", g));
    end
    run_gap();
    check_all("full9", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 4'd8);

    // ---------------- bump during MANEUVER ----------------
    load_plan(16'h0003, "bump_load");
    run_gap();
    check("bump.mnvr", {14'd0, mnvr}, 16'd3);
    repeat (5) step();
    BMPR_n = 1'b0;
    step();
    BMPR_n = 1'b1;
    check_all("bump.stop", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
    repeat (3) step();
    check_all("bump.hold", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
    load_plan(16'h0001, "bump_reload");  // expects buzz_en cleared, go=1

    // ---------------- bump coincident with 8th absent cycle -------------
    run_gap();
    check("simul.mnvr", {14'd0, mnvr}, 16'd1);
    finish_mnvr(2'b01, "simul_mnvr");
    line_present = 1'b0;
    repeat (GAP - 1) step();
    BMPL_n = 1'b0;
    step();
    BMPL_n = 1'b1;
    line_present = 1'b1;
    check_all("simul.stop", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);
    step();
    check_all("simul.after", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd1);

    // ---------------- asynchronous reset in REACQ ----------------
    load_plan(16'h0002, "rst_load");
    run_gap();
    repeat (MNV) step();  // now in REACQ
    check("rst.pre_mnvr", {14'd0, mnvr}, 16'd2);
    #2 rst = 1'b1;
    #1;
    check_all("rst.async", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    step();
    rst = 1'b0;
    line_present = 1'b0;
    repeat (GAP + 2) step();
    check_all("rst.idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    cmd = 16'h0000;
    cmd_rdy = 1'b1;
    step();
    cmd_rdy = 1'b0;
    check_all("rst.ack0", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
